rtl_fsm: RTL and testbench

Coin-acceptor / dispense controller for the vending machine datapath. It is a single-clock Moore FSM. Each clock cycle with `x` high inserts one unit coin. When accumulated credit reaches `PRICE`, it pulses a dispense code on `Z`. If credit stalls for `TIMEOUT` cycles, it pulses a refund code. It sits between the coin-detect front end and the dispense/refund actuators.

---
 rtl/rtl_fsm_if.sv | 14 +
 rtl/rtl_fsm.sv | 110 +++++++++++
 tb/tb_rtl_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rtl_fsm_if.sv
// rtl_fsm_if: coin-strobe / action-code bundle between the coin-detect
// front end and the vending controller.
//   x : 1 = one unit coin inserted this cycle (driven by the front end)
//   Z : action code, MSB is Z[1]; 00 none, 10 dispense, 01 refund
// Modports:
//   master : coin source / actuator side (drives x, observes Z)
//   slave  : controller side (observes x, drives Z)
interface rtl_fsm_if;
  logic       x;
  logic [1:2] Z;

  modport master (output x, input Z);
  modport slave  (input x, output Z);
endinterface

// File: rtl/rtl_fsm.sv
// rtl_fsm: coin-acceptor / dispense controller (Moore FSM).
// Counts unit coins on bus.x; when PRICE coins have accumulated it shows the
// dispense code for one cycle, and if partial credit sits untouched for
// TIMEOUT consecutive coin-less cycles it shows the refund code for one cycle.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous, active-high; returns to IDLE with no credit
//   bus   : rtl_fsm_if.slave -- x (coin strobe in), Z[1:2] (action code out)
// Parameters:
//   PRICE   : coins per item, 1..15
//   TIMEOUT : coin-less cycles with partial credit before refund, 1..15
module rtl_fsm #(
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 4
) (
  input  logic      clock,
  input  logic      reset,
  rtl_fsm_if.slave  bus
);

  generate
    if (PRICE < 1 || PRICE > 15) begin : g_bad_price
      $error("rtl_fsm: PRICE must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
      $error("rtl_fsm: TIMEOUT must be in 1..15");
    end
  endgenerate

  localparam logic [4:0] PRICE_C   = 5'(PRICE);
  localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);

  // Encoding chosen so that the action code is two state flops taken
  // directly: bit 2 = dispense, bit 1 = refund. Z can therefore never glitch
  // and 11 is unreachable.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    CREDIT = 3'b001,
    VEND   = 3'b100,
    REFUND = 3'b010
  } state_t;

  state_t     state, state_n;
  logic [3:0] credit, credit_n;
  logic [3:0] idle, idle_n;
  logic [4:0] credit_inc, idle_inc;

  // One bit wider than the counters so the compare against the limit is
  // made before any wrap could happen.
  assign credit_inc = {1'b0, credit} + 5'd1;
  assign idle_inc   = {1'b0, idle} + 5'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      credit <= 4'd0;
      idle   <= 4'd0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      idle   <= idle_n;
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit;
    idle_n   = idle;
    case (state)
      CREDIT: begin
        if (bus.x) begin
          // A coin always beats a coincident timeout.
          idle_n = 4'd0;
          if (credit_inc == PRICE_C) begin
            state_n  = VEND;
            credit_n = 4'd0;
          end else begin
            credit_n = credit_inc[3:0];
          end
        end else if (idle_inc == TIMEOUT_C) begin
          state_n  = REFUND;
          credit_n = 4'd0;
          idle_n   = 4'd0;
        end else begin
          idle_n = idle_inc[3:0];
        end
      end
      default: begin
        // IDLE, VEND and REFUND all start from zero credit; a coin seen in a
        // VEND/REFUND cycle opens a fresh transaction so it is neither lost
        // nor folded into the amount just vended or refunded.
        credit_n = 4'd0;
        idle_n   = 4'd0;
        if (bus.x) begin
          if (PRICE_C == 5'd1) begin
            state_n = VEND;
          end else begin
            state_n  = CREDIT;
            credit_n = 4'd1;
          end
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  assign bus.Z = state[2:1];

endmodule

// File: tb/tb_rtl_fsm.sv
// tb_rtl_fsm: directed bench for rtl_fsm with default PRICE=3, TIMEOUT=4.
// A coin-counting model predicts Z after every edge; a compare process checks
// the DUT against it every cycle, and each directed step also checks both the
// DUT and the model against a hand-computed literal.
module tb_rtl_fsm;
  localparam int PRICE   = 3;
  localparam int TIMEOUT = 4;

  logic clock = 1'b0;
  logic reset;
  logic started = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  rtl_fsm_if bus ();

  rtl_fsm #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: coins held, quiet cycles since last coin, action shown.
  int         m_coins = 0;
  int         m_quiet = 0;
  logic [1:2] mdl_z   = 2'b00;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_coins = 0;
      m_quiet = 0;
      mdl_z   = 2'b00;
    end else if (bus.x) begin
      m_coins = m_coins + 1;
      m_quiet = 0;
      if (m_coins == PRICE) begin
        mdl_z   = 2'b10;
        m_coins = 0;
      end else begin
        mdl_z = 2'b00;
      end
    end else if (m_coins > 0) begin
      m_quiet = m_quiet + 1;
      if (m_quiet == TIMEOUT) begin
        mdl_z   = 2'b01;
        m_coins = 0;
        m_quiet = 0;
      end else begin
        mdl_z = 2'b00;
      end
    end else begin
      mdl_z = 2'b00;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      n_chk++;
      if (bus.Z !== mdl_z) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: Z=%b expected %b", $time, bus.Z, mdl_z);
      end
    end
  end

  task automatic check(input string nm, input logic [1:2] act, input logic [1:2] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle from a falling edge, check Z just after the rising edge.
  task automatic step(input logic xv, input logic rv, input logic [1:2] ez, input string nm);
    bus.x = xv;
    reset = rv;
    @(posedge clock);
    #1;
    check(nm, bus.Z, ez);
    check({"pin_", nm}, mdl_z, ez);
    @(negedge clock);
  endtask

  logic [1:2] exp9 [9];

  initial begin
    reset = 1'b1;
    bus.x = 1'b1;
    @(negedge clock);
    started = 1'b1;

    // Reset held with coins present, then idle with no credit.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b00, "rst_hold");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b00, "idle_quiet");

    // Continuous coins: vend after coins 3, 6, 9 with no gap.
    exp9 = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, exp9[i], "stream");
    step(1'b0, 1'b0, 2'b00, "stream_end");

    // Two coins then silence: refund shown after the 4th quiet edge only.
    step(1'b1, 1'b0, 2'b00, "to_c1");
    step(1'b1, 1'b0, 2'b00, "to_c2");
    step(1'b0, 1'b0, 2'b00, "to_q1");
    step(1'b0, 1'b0, 2'b00, "to_q2");
    step(1'b0, 1'b0, 2'b00, "to_q3");
    step(1'b0, 1'b0, 2'b01, "to_refund");
    step(1'b0, 1'b0, 2'b00, "to_after1");
    step(1'b0, 1'b0, 2'b00, "to_after2");

    // Coin during the VEND cycle starts a new transaction.
    step(1'b1, 1'b0, 2'b00, "vc_c1");
    step(1'b1, 1'b0, 2'b00, "vc_c2");
    step(1'b1, 1'b0, 2'b10, "vc_vend1");
    step(1'b1, 1'b0, 2'b00, "vc_carry");
    step(1'b1, 1'b0, 2'b00, "vc_c2b");
    step(1'b1, 1'b0, 2'b10, "vc_vend2");
    step(1'b0, 1'b0, 2'b00, "vc_end");

    // Coin on the edge that would expire the timeout wins.
    step(1'b1, 1'b0, 2'b00, "race_c1");
    step(1'b0, 1'b0, 2'b00, "race_q1");
    step(1'b0, 1'b0, 2'b00, "race_q2");
    step(1'b0, 1'b0, 2'b00, "race_q3");
    step(1'b1, 1'b0, 2'b00, "race_coin");
    step(1'b1, 1'b0, 2'b10, "race_vend");
    step(1'b0, 1'b0, 2'b00, "race_end");

    // Asynchronous reset between edges with credit=2.
    step(1'b1, 1'b0, 2'b00, "ar_c1");
    step(1'b1, 1'b0, 2'b00, "ar_c2");
    #2 reset = 1'b1;
    #1 check("ar_credit_now", bus.Z, 2'b00);
    @(negedge clock);
    step(1'b0, 1'b1, 2'b00, "ar_hold");
    step(1'b1, 1'b0, 2'b00, "ar_new1");
    step(1'b1, 1'b0, 2'b00, "ar_new2");
    step(1'b1, 1'b0, 2'b10, "ar_new_vend");
    // Reset while the dispense code is showing clears it at once.
    #2 reset = 1'b1;
    #1 check("ar_vend_now", bus.Z, 2'b00);
    @(negedge clock);
    step(1'b1, 1'b1, 2'b00, "ar_hold2");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b00, "ar_no_refund");

    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
